// File: rtl/comm_parallel_regfile.sv
// Host-facing parallel register file: async write/read strobes, one access per strobe, four-phase ack.
// Latency: strobe rise -> access + ack high after SYNC_STAGES+1 clk edges; strobe fall -> ack low after SYNC_STAGES+1.
// Backpressure: ack held high until both synchronised strobes are low; edges seen while acking are dropped.
//
// Ports:
//   clk, rst           single clock, asynchronous active-high reset
//   inData, addr       host write data / address, stable around the strobe
//   writeData/readData asynchronous host strobes (rising edge = request)
//   autoInc            1 = address from internal pointer, which advances on each valid access
//   outData            registered read data, held until the next valid read
//   ack                four-phase acknowledge
//   err, clrErr        sticky error (bad address or write/read collision), synchronous clear
//   ptr                current internal pointer
module comm_parallel_regfile #(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inData,
  output logic [DATA_W-1:0] outData,
  input  logic [ADDR_W-1:0] addr,
  input  logic              writeData,
  input  logic              readData,
  input  logic              autoInc,
  output logic              ack,
  output logic              err,
  input  logic              clrErr,
  output logic [ADDR_W-1:0] ptr
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] w_sync, r_sync;
  logic                   w_s_d, r_s_d;
  logic                   w_s, r_s, w_e, r_e;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] eff_addr;
  logic [IDX_W-1:0]  idx;
  logic              addr_ok;
  logic              do_wr, do_rd, set_err, bump_ptr;

  // Strobe synchronisers plus one extra flop each for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_sync <= '0;
      r_sync <= '0;
      w_s_d  <= 1'b0;
      r_s_d  <= 1'b0;
    end else begin
      w_sync <= {w_sync[SYNC_STAGES-2:0], writeData};
      r_sync <= {r_sync[SYNC_STAGES-2:0], readData};
      w_s_d  <= w_s;
      r_s_d  <= r_s;
    end
  end

  assign w_s = w_sync[SYNC_STAGES-1];
  assign r_s = r_sync[SYNC_STAGES-1];
  assign w_e = w_s & ~w_s_d;
  assign r_e = r_s & ~r_s_d;

  assign eff_addr = autoInc ? ptr : addr;
  assign addr_ok  = {1'b0, eff_addr} < DEPTH_V;
  assign idx      = eff_addr[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and one-cycle access strobes for the datapath.
  always_comb begin
    state_nxt = state;
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    set_err   = 1'b0;
    bump_ptr  = 1'b0;
    case (state)
      IDLE: begin
        if (w_e && r_e) begin
          // Collision: no access, but still acknowledge so the host never hangs.
          set_err   = 1'b1;
          state_nxt = ACK;
        end else if (w_e || r_e) begin
          state_nxt = ACK;
          if (addr_ok) begin
            do_wr    = w_e;
            do_rd    = r_e;
            bump_ptr = autoInc;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      ACK: begin
        if (!w_s && !r_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ack = (state == ACK);

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[idx] <= inData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outData <= '0;
      err     <= 1'b0;
      ptr     <= '0;
    end else begin
      if (do_rd) outData <= mem[idx];

      // A new error in the same cycle as a clear wins.
      if (set_err)     err <= 1'b1;
      else if (clrErr) err <= 1'b0;

      // Pointer advances on valid auto-increment accesses; otherwise it
      // shadows the host address while idle so a burst can be preset.
      if (bump_ptr)                    ptr <= (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
      else if (state == IDLE && !autoInc) ptr <= addr;
    end
  end

endmodule

// File: tb/tb_comm_parallel_regfile.sv
// Bench for comm_parallel_regfile: transaction-level model of memory/outData/err/ptr/ack,
// compared against the DUT on every falling clock edge, plus literal spot checks.
// Inputs are driven 1 time unit after the rising edge.
module tb_comm_parallel_regfile;

  localparam int DW = 4;
  localparam int AW = 9;
  localparam int DEPTH = 256;

  logic          clk;
  logic          rst;
  logic [DW-1:0] inData;
  logic [DW-1:0] outData;
  logic [AW-1:0] addr;
  logic          writeData;
  logic          readData;
  logic          autoInc;
  logic          ack;
  logic          err;
  logic          clrErr;
  logic [AW-1:0] ptr;

  comm_parallel_regfile #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .inData(inData), .outData(outData), .addr(addr),
    .writeData(writeData), .readData(readData), .autoInc(autoInc),
    .ack(ack), .err(err), .clrErr(clrErr), .ptr(ptr)
  );

  int errors = 0;
  int checks = 0;

  // Model state
  logic [DW-1:0] exp_mem [0:DEPTH-1];
  logic          exp_ack;
  logic          exp_err;
  logic [DW-1:0] exp_out;
  logic [AW-1:0] exp_ptr;
  bit            chk_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", 32'(ack), 32'(exp_ack));
      check("outData", 32'(outData), 32'(exp_out));
      check("err", 32'(err), 32'(exp_err));
      check("ptr", 32'(ptr), 32'(exp_ptr));
    end
  end

  task automatic set_ptr(input logic [AW-1:0] a);
    addr = a;
    autoInc = 1'b0;
    tick();
    exp_ptr = a;
  endtask

  task automatic clear_err();
    clrErr = 1'b1;
    tick();
    exp_err = 1'b0;
    clrErr = 1'b0;
    tick();
  endtask

  // One complete four-phase transaction. hold = cycles the strobe stays up after ack rises.
  // clr = pulse clrErr in the cycle the access takes effect.
  task automatic access(input bit wr, input bit rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit ai, input int hold, input bit clr);
    logic [AW-1:0] ea;
    bit            bad;
    addr = a;
    inData = d;
    autoInc = ai;
    tick();
    if (!ai) exp_ptr = a;
    tick();
    tick();
    writeData = wr;
    readData = rd;
    tick();
    tick();
    clrErr = clr;
    tick();
    clrErr = 1'b0;
    // Access takes effect on the third edge after the strobe rises.
    exp_ack = 1'b1;
    ea = ai ? exp_ptr : a;
    bad = (wr && rd) || (int'(ea) >= DEPTH);
    if (bad) begin
      exp_err = 1'b1;
    end else begin
      if (wr) exp_mem[ea[7:0]] = d;
      else    exp_out = exp_mem[ea[7:0]];
      if (ai) exp_ptr = (int'(exp_ptr) == DEPTH - 1) ? '0 : exp_ptr + 9'd1;
      if (clr) exp_err = 1'b0;
    end
    repeat (hold) tick();
    writeData = 1'b0;
    readData = 1'b0;
    tick();
    tick();
    tick();
    exp_ack = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required finish before t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    inData = '0;
    addr = '0;
    writeData = 1'b0;
    readData = 1'b0;
    autoInc = 1'b0;
    clrErr = 1'b0;
    exp_ack = 1'b0;
    exp_err = 1'b0;
    exp_out = '0;
    exp_ptr = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_out", 32'(outData), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ptr", 32'(ptr), 32'd0);
    chk_en = 1;

    // Basic write then read
    access(1, 0, 9'd5, 4'hA, 0, 2, 0);
    access(0, 1, 9'd5, 4'h0, 0, 2, 0);
    check("t1_read5", 32'(outData), 32'hA);

    // Strobe held 20 cycles: exactly one access, pointer moves once
    set_ptr(9'd20);
    access(1, 0, 9'd0, 4'h6, 1, 17, 0);
    check("t2_ptr_once", 32'(ptr), 32'd21);
    access(0, 1, 9'd20, 4'h0, 0, 2, 0);
    check("t2_read20", 32'(outData), 32'h6);

    // Auto-increment burst across the top of memory
    set_ptr(9'd254);
    access(1, 0, 9'd0, 4'h1, 1, 1, 0);
    access(1, 0, 9'd0, 4'h2, 1, 1, 0);
    access(1, 0, 9'd0, 4'h3, 1, 1, 0);
    check("t3_ptr_wrap", 32'(ptr), 32'd1);
    access(0, 1, 9'd254, 4'h0, 0, 1, 0);
    check("t3_read254", 32'(outData), 32'h1);
    access(0, 1, 9'd255, 4'h0, 0, 1, 0);
    check("t3_read255", 32'(outData), 32'h2);
    access(0, 1, 9'd0, 4'h0, 0, 1, 0);
    check("t3_read0", 32'(outData), 32'h3);

    // Invalid addresses
    access(1, 0, 9'd300, 4'hC, 0, 2, 0);
    check("t4_err_set", 32'(err), 32'd1);
    access(0, 1, 9'd256, 4'h0, 0, 2, 0);
    check("t4_out_kept", 32'(outData), 32'h3);
    clear_err();
    check("t4_err_clr", 32'(err), 32'd0);
    set_ptr(9'd300);
    access(1, 0, 9'd0, 4'h9, 1, 2, 0);
    check("t4_ptr_stuck", 32'(ptr), 32'd300);
    clear_err();
    access(1, 0, 9'd400, 4'h9, 0, 2, 1);
    check("t4_set_wins", 32'(err), 32'd1);
    clear_err();
    access(0, 1, 9'd0, 4'h0, 0, 1, 0);
    check("t4_mem_untouched", 32'(outData), 32'h3);

    // Write/read collision
    access(0, 1, 9'd5, 4'h0, 0, 1, 0);
    access(1, 1, 9'd5, 4'hF, 0, 2, 0);
    check("t5_err", 32'(err), 32'd1);
    check("t5_out_kept", 32'(outData), 32'hA);
    access(0, 1, 9'd5, 4'h0, 0, 1, 0);
    check("t5_mem_kept", 32'(outData), 32'hA);

    // Reset in the middle of an acknowledged read (err still set from the collision)
    addr = 9'd20;
    autoInc = 1'b0;
    tick();
    exp_ptr = 9'd20;
    tick();
    tick();
    readData = 1'b1;
    tick();
    tick();
    tick();
    exp_ack = 1'b1;
    exp_out = exp_mem[20];
    tick();
    check("t6_pre_ack", 32'(ack), 32'd1);
    chk_en = 0;
    rst = 1'b1;
    #1;
    check("t6_ack_async", 32'(ack), 32'd0);
    check("t6_out_async", 32'(outData), 32'd0);
    check("t6_err_async", 32'(err), 32'd0);
    readData = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_ack = 1'b0;
    exp_out = '0;
    exp_err = 1'b0;
    tick();
    exp_ptr = 9'd20;
    chk_en = 1;
    access(0, 1, 9'd5, 4'h0, 0, 1, 0);
    check("t6_after_rst", 32'(outData), 32'hA);
    access(1, 0, 9'd7, 4'h5, 0, 1, 0);
    access(0, 1, 9'd7, 4'h0, 0, 1, 0);
    check("t6_rw7", 32'(outData), 32'h5);

    chk_en = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
